// File: rtl/noc_client_rx.sv
// Client-side receive buffer: one FIFO per virtual channel fed from the leaf switch,
// drained to the client through a round-robin arbiter.
module noc_client_rx #(
    parameter int N     = 4,
    parameter int A_W   = 4,
    parameter int D_W   = 32,
    parameter int VC_W  = 2,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [A_W+D_W:0]          i,
    input  logic [VC_W-1:0]           i_v,
    output logic [VC_W-1:0]           i_bp,
    output logic [A_W+D_W:0]          o_data,
    output logic [$clog2(VC_W)-1:0]   o_vc,
    output logic                      o_valid,
    input  logic                      o_ready,
    output logic                      err
);

    localparam int FW = A_W + D_W + 1;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int VW = $clog2(VC_W);

    if (N < 1 || VC_W < 2 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
        $error("noc_client_rx: illegal parameterisation");
    end

    logic [FW-1:0]   mem_q    [VC_W][DEPTH];
    logic [PW-1:0]   wr_ptr_q [VC_W];
    logic [PW-1:0]   rd_ptr_q [VC_W];
    logic [CW-1:0]   count_q  [VC_W];
    logic [VW-1:0]   rr_q;
    logic [VW-1:0]   hold_vc_q;
    logic            hold_q;
    logic            err_q;

    logic [VC_W-1:0] nonempty;
    logic [VC_W-1:0] eligible;
    logic [VC_W-1:0] push_sel;
    logic [VC_W-1:0] pop_sel;
    logic [VW-1:0]   grant;
    logic            pop;
    logic            multi_v;
    logic            err_d;

    always_comb begin
        for (int v = 0; v < VC_W; v++) begin
            nonempty[v] = (count_q[v] != '0);
            i_bp[v]     = (count_q[v] == CW'(DEPTH));
        end
    end

    // Lowest set bit of the eligible vector picks the single VC that gets pushed.
    assign eligible = i_v & ~i_bp;
    assign push_sel = eligible & (~eligible + 1'b1);
    assign multi_v  = (i_v & (i_v - 1'b1)) != '0;
    assign err_d    = err_q | multi_v | (|(i_v & i_bp));

    // While a presented flit is stalled, the grant is pinned so o_data cannot change under
    // the client when a VC nearer to rr becomes non-empty.
    // NOTE: every variable written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        grant = hold_vc_q;
        if (!hold_q) begin
            grant = '0;
            for (int k = VC_W - 1; k >= 0; k--) begin
                if (nonempty[(int'(rr_q) + k) % VC_W]) begin
                    grant = VW'((int'(rr_q) + k) % VC_W);
                end
            end
        end
    end

    assign o_valid = |nonempty;
    assign o_vc    = o_valid ? grant : '0;
    assign o_data  = o_valid ? mem_q[grant][rd_ptr_q[grant]] : '0;
    assign pop     = o_valid & o_ready;
    assign err     = err_q;

    always_comb begin
        pop_sel        = '0;
        pop_sel[grant] = pop;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < VC_W; v++) begin
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
                count_q[v]  <= '0;
            end
            rr_q      <= '0;
            hold_q    <= 1'b0;
            hold_vc_q <= '0;
            err_q     <= 1'b0;
        end else begin
            for (int v = 0; v < VC_W; v++) begin
                if (push_sel[v]) wr_ptr_q[v] <= wr_ptr_q[v] + 1'b1;
                if (pop_sel[v])  rd_ptr_q[v] <= rd_ptr_q[v] + 1'b1;
                if (push_sel[v] && !pop_sel[v]) begin
                    count_q[v] <= count_q[v] + 1'b1;
                end else if (pop_sel[v] && !push_sel[v]) begin
                    count_q[v] <= count_q[v] - 1'b1;
                end
            end
            if (pop) begin
                rr_q <= (grant == VW'(VC_W - 1)) ? '0 : grant + 1'b1;
            end
            hold_q <= o_valid & ~o_ready;
            if (o_valid && !o_ready) begin
                hold_vc_q <= grant;
            end
            err_q <= err_d;
        end
    end

    // NOTE: flit storage is deliberately not reset; pointers and counts alone decide what is valid.
    always_ff @(posedge clk) begin
        for (int v = 0; v < VC_W; v++) begin
            if (push_sel[v]) mem_q[v][wr_ptr_q[v]] <= i;
        end
    end

endmodule

// File: tb/tb_noc_client_rx.sv
// Scoreboard bench for noc_client_rx: per-VC flit queues plus a round-robin model,
// checked every cycle by an independent negedge monitor.
module tb_noc_client_rx;

    localparam int A_W   = 4;
    localparam int D_W   = 32;
    localparam int VC_W  = 2;
    localparam int DEPTH = 4;
    localparam int FW    = A_W + D_W + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [FW-1:0] i_flit = '0;
    logic [1:0]    i_v = '0;
    logic [1:0]    i_bp;
    logic [FW-1:0] o_data;
    logic          o_vc;
    logic          o_valid;
    logic          o_ready = 1'b0;
    logic          err;

    int checks = 0;
    int errors = 0;

    // Reference model: what the client should see, kept as plain queues.
    logic [FW-1:0] q0 [$];
    logic [FW-1:0] q1 [$];
    int            rr_m = 0;
    bit            hold_m = 1'b0;
    int            hold_vc_m = 0;
    bit            err_m = 1'b0;
    bit            done = 1'b0;

    always #5 clk = ~clk;

    noc_client_rx #(
        .N(4), .A_W(A_W), .D_W(D_W), .VC_W(VC_W), .DEPTH(DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i       (i_flit),
        .i_v     (i_v),
        .i_bp    (i_bp),
        .o_data  (o_data),
        .o_vc    (o_vc),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .err     (err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int v);
        return (v == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [FW-1:0] qhead(input int v);
        return (v == 0) ? q0[0] : q1[0];
    endfunction

    // Flit the client should be offered: the stalled one, else first non-empty VC from rr.
    function automatic int exp_grant();
        if (hold_m) return hold_vc_m;
        for (int k = 0; k < VC_W; k++) begin
            if (qsize((rr_m + k) % VC_W) > 0) return (rr_m + k) % VC_W;
        end
        return -1;
    endfunction

    function automatic void model_clear();
        q0.delete();
        q1.delete();
        rr_m      = 0;
        hold_m    = 1'b0;
        hold_vc_m = 0;
        err_m     = 1'b0;
    endfunction

    task automatic model_edge();
        int g;
        int pushed;
        int nv;
        g      = exp_grant();
        pushed = -1;
        nv     = 0;
        for (int v = 0; v < VC_W; v++) begin
            if (i_v[v]) begin
                nv++;
                if (qsize(v) == DEPTH) err_m = 1'b1;
                else if (pushed < 0) pushed = v;
            end
        end
        if (nv > 1) err_m = 1'b1;
        hold_m = (g >= 0) && !o_ready;
        if (hold_m) hold_vc_m = g;
        if (g >= 0 && o_ready) begin
            if (g == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
            rr_m = (g + 1) % VC_W;
        end
        if (pushed == 0) q0.push_back(i_flit);
        if (pushed == 1) q1.push_back(i_flit);
    endtask

    task automatic step(input logic [1:0] v, input logic [FW-1:0] d, input logic rdy);
        i_v     = v;
        i_flit  = d;
        o_ready = rdy;
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    always @(negedge clk) begin
        int g;
        if (!done) begin
            g = exp_grant();
            check("o_valid", 64'(o_valid), 64'(g >= 0));
            check("o_vc", 64'(o_vc), (g >= 0) ? 64'(g) : 64'd0);
            check("o_data", 64'(o_data), (g >= 0) ? 64'(qhead(g)) : 64'd0);
            check("i_bp0", 64'(i_bp[0]), 64'(q0.size() == DEPTH));
            check("i_bp1", 64'(i_bp[1]), 64'(q1.size() == DEPTH));
            check("err", 64'(err), 64'(err_m));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int r;
        logic [1:0] v;

        model_clear();
        step(2'b00, '0, 1'b0);
        check("rst o_valid", 64'(o_valid), 64'd0);
        check("rst i_bp", 64'(i_bp), 64'd0);
        check("rst err", 64'(err), 64'd0);
        rst_n = 1'b1;

        // Single flit, pushed on the very first edge after reset release.
        step(2'b01, {1'b0, 4'b1010, 32'hABCDABCD}, 1'b1);
        step(2'b00, '0, 1'b1);
        step(2'b00, '0, 1'b1);

        // Fill VC1 with the client stalled, overflow it, then drain.
        for (int k = 0; k < DEPTH; k++) step(2'b10, FW'(32'h100 + k), 1'b0);
        check("full i_bp", 64'(i_bp), 64'h2);
        step(2'b10, FW'(32'h1FF), 1'b0);
        check("overflow err", 64'(err), 64'd1);
        step(2'b00, '0, 1'b1);
        check("bp after pop", 64'(i_bp), 64'd0);
        for (int k = 0; k < DEPTH; k++) step(2'b00, '0, 1'b1);

        // Two valids at once: only VC0 takes the flit.
        step(2'b11, FW'(32'h55), 1'b1);
        step(2'b00, '0, 1'b1);
        step(2'b00, '0, 1'b1);

        // Three flits on each VC, then interleaved delivery.
        for (int k = 0; k < 3; k++) begin
            step(2'b01, FW'(32'h200 + k), 1'b0);
            step(2'b10, FW'(32'h300 + k), 1'b0);
        end
        for (int k = 0; k < 7; k++) step(2'b00, '0, 1'b1);

        // Incrementing 16-flit stream through VC0 kept at or near full.
        sent = 0;
        for (int c = 0; c < 60 && (sent < 16 || q0.size() > 0); c++) begin
            if (sent < 16 && q0.size() < DEPTH) begin
                step(2'b01, FW'(32'hA000 + sent), c >= 4);
                sent++;
            end else begin
                step(2'b00, '0, c >= 4);
            end
        end
        check("stream sent", 64'(sent), 64'd16);

        // Reset between edges discards buffered flits at once.
        for (int k = 0; k < 3; k++) step(2'b01, FW'(32'h700 + k), 1'b0);
        #3;
        rst_n = 1'b0;
        model_clear();
        #1;
        check("midrst o_valid", 64'(o_valid), 64'd0);
        check("midrst i_bp", 64'(i_bp), 64'd0);
        step(2'b00, '0, 1'b0);
        step(2'b00, '0, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) step(2'b00, '0, 1'b1);
        step(2'b10, FW'(32'h800), 1'b0);
        step(2'b00, '0, 1'b1);

        // Randomised traffic against the model.
        for (int c = 0; c < 400; c++) begin
            r = $urandom_range(0, 9);
            v = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            step(v, FW'({$urandom(), $urandom()}), $urandom_range(0, 3) != 0);
        end
        step(2'b00, '0, 1'b1);

        @(negedge clk);
        #1;
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
